// File: rtl/mem_wb_ctrl.sv
// EX->MEM->WB writeback controller: ALU results pass straight through, loads stall
// for the read latency, then write back lane-extracted, sign/zero-extended data.
// Optional variable-latency mode: define MEM_WB_VARLAT_EN (waits on mem_rvalid_i).
`ifndef MEM_READ
`define MEM_READ 1'b1
`endif

module mem_wb_ctrl #(
  parameter int XLEN     = 32,
  parameter int REG_W    = 5,
  parameter int LOAD_LAT = 1,
  parameter int OFF_W    = $clog2(XLEN/8)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ex_valid,
  input  logic             ex_mem_ena,
  input  logic             mem_rw_i,
  input  logic [1:0]       ex_ld_size,
  input  logic             ex_ld_unsigned,
  input  logic [OFF_W-1:0] ex_addr_off,
  input  logic [REG_W-1:0] gprs_waddr_i,
  input  logic [XLEN-1:0]  gprs_wdata_i,
  input  logic [XLEN-1:0]  mem_rdata_i,
  input  logic             mem_rvalid_i,
  output logic [REG_W-1:0] gprs_waddr_o,
  output logic [XLEN-1:0]  gprs_wdata_o,
  output logic             stall
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] WAIT = 1'b1;

  // Handshake: stall=1 freezes EX, which keeps presenting the same instruction;
  // a load is accepted in IDLE and retires (stall=0, GPRS write) in the WB cycle,
  // during which the still-held EX load is ignored.
  logic [0:0]       state;
  logic [REG_W-1:0] rd_q;
  logic [1:0]       size_q;
  logic             uns_q;
  logic [OFF_W-1:0] lane_q;
  logic             load_req;
  logic             wb_now;

  assign load_req = ex_valid && ex_mem_ena && (mem_rw_i == `MEM_READ);

`ifdef MEM_WB_VARLAT_EN
  localparam int unused_lat = LOAD_LAT;
  assign wb_now = (state == WAIT) && mem_rvalid_i;
`else
  localparam int CNT_W = $clog2(LOAD_LAT+1);
  logic [CNT_W-1:0] cnt;
  logic unused_rvalid;
  assign unused_rvalid = mem_rvalid_i;
  assign wb_now = (state == WAIT) && (cnt == '0);
`endif

  // Lane extraction: shift the field down to bit 0, then mask and extend.
  logic [OFF_W+2:0] shamt;
  logic [XLEN-1:0]  sh;
  logic [XLEN-1:0]  mask;
  logic             msb;
  logic [XLEN-1:0]  ld_data;

  always_comb begin
    shamt = '0;
    mask  = '1;
    case (size_q)
      2'd0: begin
        shamt = {lane_q, 3'b000};
        mask  = XLEN'(8'hFF);
      end
      2'd1: begin
        shamt = {lane_q & ~OFF_W'(1), 3'b000};
        mask  = XLEN'(16'hFFFF);
      end
      2'd2: begin
        shamt = (XLEN == 64) ? {lane_q & ~OFF_W'(3), 3'b000} : '0;
        mask  = XLEN'(32'hFFFF_FFFF);
      end
      default: begin
        shamt = '0;
        mask  = '1;
      end
    endcase
    sh = mem_rdata_i >> shamt;
    case (size_q)
      2'd0:    msb = sh[7];
      2'd1:    msb = sh[15];
      2'd2:    msb = sh[31];
      default: msb = sh[XLEN-1];
    endcase
    ld_data = (sh & mask) | ((msb && !uns_q) ? ~mask : '0);
  end

  always_comb begin
    gprs_waddr_o = '0;
    gprs_wdata_o = '0;
    stall        = 1'b0;
    if (!rst) begin
      case (state)
        IDLE: begin
          if (ex_valid && !ex_mem_ena) begin
            gprs_waddr_o = gprs_waddr_i;
            gprs_wdata_o = gprs_wdata_i;
          end else if (load_req) begin
            stall = 1'b1;
          end
        end
        default: begin
          if (wb_now) begin
            gprs_waddr_o = rd_q;
            gprs_wdata_o = ld_data;
          end else begin
            stall = 1'b1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      rd_q   <= '0;
      size_q <= '0;
      uns_q  <= 1'b0;
      lane_q <= '0;
`ifndef MEM_WB_VARLAT_EN
      cnt    <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (load_req) begin
            state  <= WAIT;
            rd_q   <= gprs_waddr_i;
            size_q <= ex_ld_size;
            uns_q  <= ex_ld_unsigned;
            lane_q <= ex_addr_off;
`ifndef MEM_WB_VARLAT_EN
            cnt    <= CNT_W'(LOAD_LAT-1);
`endif
          end
        end
        default: begin
          if (wb_now) begin
            state <= IDLE;
          end
`ifndef MEM_WB_VARLAT_EN
          else begin
            cnt <= cnt - CNT_W'(1);
          end
`endif
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_wb_ctrl.sv
// Directed bench for mem_wb_ctrl: dut_a is XLEN=32/LOAD_LAT=3, dut_b is XLEN=64/LOAD_LAT=2.
`ifndef MEM_READ
`define MEM_READ 1'b1
`endif

module tb_mem_wb_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid, ex_mem_ena, mem_rw, ld_uns, rvalid;
  logic [1:0]  ld_size;
  logic [2:0]  off;
  logic [4:0]  waddr;
  logic [63:0] wdata, rdata;

  logic [4:0]  a_waddr, b_waddr;
  logic [31:0] a_wdata;
  logic [63:0] b_wdata;
  logic        a_stall, b_stall;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_wb_ctrl #(.XLEN(32), .REG_W(5), .LOAD_LAT(3)) dut_a (
    .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_mem_ena(ex_mem_ena),
    .mem_rw_i(mem_rw), .ex_ld_size(ld_size), .ex_ld_unsigned(ld_uns),
    .ex_addr_off(off[1:0]), .gprs_waddr_i(waddr), .gprs_wdata_i(wdata[31:0]),
    .mem_rdata_i(rdata[31:0]), .mem_rvalid_i(rvalid),
    .gprs_waddr_o(a_waddr), .gprs_wdata_o(a_wdata), .stall(a_stall)
  );

  mem_wb_ctrl #(.XLEN(64), .REG_W(5), .LOAD_LAT(2)) dut_b (
    .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_mem_ena(ex_mem_ena),
    .mem_rw_i(mem_rw), .ex_ld_size(ld_size), .ex_ld_unsigned(ld_uns),
    .ex_addr_off(off), .gprs_waddr_i(waddr), .gprs_wdata_i(wdata),
    .mem_rdata_i(rdata), .mem_rvalid_i(rvalid),
    .gprs_waddr_o(b_waddr), .gprs_wdata_o(b_wdata), .stall(b_stall)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    ex_valid = 1'b0; ex_mem_ena = 1'b0; mem_rw = ~`MEM_READ;
    ld_size = 2'd0; ld_uns = 1'b0; off = 3'd0; waddr = 5'd0;
    wdata = 64'd0; rdata = 64'd0; rvalid = 1'b0;
  endtask

  task automatic do_reset();
    drive_idle();
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
  endtask

  task automatic set_load(input logic [1:0] sz, input logic uns, input logic [2:0] o,
                          input logic [4:0] rd, input logic [63:0] rd_data);
    ex_valid = 1'b1; ex_mem_ena = 1'b1; mem_rw = `MEM_READ;
    ld_size = sz; ld_uns = uns; off = o; waddr = rd; rdata = rd_data;
  endtask

  // Expects n_stall stalled cycles starting now, then the WB cycle; leaves EX inputs held.
  task automatic run_load(input bit on_a, input int n_stall, input logic [4:0] rd,
                          input logic [63:0] exp_data);
    for (int i = 0; i < n_stall; i++) begin
      @(negedge clk);
      check("ld_stall", on_a ? {63'd0, a_stall} : {63'd0, b_stall}, 64'd1);
      check("ld_waddr_busy", on_a ? {59'd0, a_waddr} : {59'd0, b_waddr}, 64'd0);
      next_cycle();
      if (i == n_stall - 1) rvalid = 1'b1;
    end
    @(negedge clk);
    check("wb_stall", on_a ? {63'd0, a_stall} : {63'd0, b_stall}, 64'd0);
    check("wb_waddr", on_a ? {59'd0, a_waddr} : {59'd0, b_waddr}, {59'd0, rd});
    check("wb_wdata", on_a ? {32'd0, a_wdata} : b_wdata, exp_data);
    next_cycle();
    rvalid = 1'b0;
  endtask

  initial begin
    drive_idle();
    rst = 1'b1;
    ex_valid = 1'b1; waddr = 5'd5; wdata = 64'h1234;
    @(negedge clk);
    check("rst_waddr_a", {59'd0, a_waddr}, 64'd0);
    check("rst_wdata_a", {32'd0, a_wdata}, 64'd0);
    check("rst_stall_a", {63'd0, a_stall}, 64'd0);
    check("rst_waddr_b", {59'd0, b_waddr}, 64'd0);
    next_cycle();
    rst = 1'b0;

    // ALU pass-through
    @(negedge clk);
    check("alu_waddr_a", {59'd0, a_waddr}, 64'd5);
    check("alu_wdata_a", {32'd0, a_wdata}, 64'h1234);
    check("alu_stall_a", {63'd0, a_stall}, 64'd0);
    check("alu_waddr_b", {59'd0, b_waddr}, 64'd5);
    check("alu_wdata_b", b_wdata, 64'h1234);
    next_cycle();

    // Store: no write, no stall
    ex_mem_ena = 1'b1; mem_rw = ~`MEM_READ; waddr = 5'd7;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("st_waddr_a", {59'd0, a_waddr}, 64'd0);
      check("st_stall_a", {63'd0, a_stall}, 64'd0);
      check("st_waddr_b", {59'd0, b_waddr}, 64'd0);
      check("st_stall_b", {63'd0, b_stall}, 64'd0);
      next_cycle();
    end

    // Invalid instruction with ALU fields
    ex_valid = 1'b0; ex_mem_ena = 1'b0; waddr = 5'd6;
    @(negedge clk);
    check("inv_waddr_a", {59'd0, a_waddr}, 64'd0);
    next_cycle();

    // XLEN=32, LOAD_LAT=3 loads
    do_reset(); set_load(2'd0, 1'b0, 3'd2, 5'd9, 64'h0080_0000);
    run_load(1'b1, 3, 5'd9, 64'hFFFF_FF80);
    do_reset(); set_load(2'd0, 1'b1, 3'd1, 5'd0, 64'h0000_AB00);
    run_load(1'b1, 3, 5'd0, 64'h0000_00AB);
    do_reset(); set_load(2'd3, 1'b0, 3'd0, 5'd8, 64'hCAFE_F00D);
    run_load(1'b1, 3, 5'd8, 64'hCAFE_F00D);

    // XLEN=64, LOAD_LAT=2 loads
    do_reset(); set_load(2'd1, 1'b1, 3'd6, 5'd10, 64'h8001_0000_0000_0000);
    run_load(1'b0, 2, 5'd10, 64'h0000_0000_0000_8001);
    do_reset(); set_load(2'd1, 1'b0, 3'd3, 5'd12, 64'h0000_0000_8765_0000);
    run_load(1'b0, 2, 5'd12, 64'hFFFF_FFFF_FFFF_8765);
    do_reset(); set_load(2'd3, 1'b0, 3'd0, 5'd16, 64'h0123_4567_89AB_CDEF);
    run_load(1'b0, 2, 5'd16, 64'h0123_4567_89AB_CDEF);

    // Back-to-back: second load accepted in the cycle right after WB
    do_reset(); set_load(2'd2, 1'b1, 3'd4, 5'd11, 64'hFFFF_FFFF_0000_0000);
    run_load(1'b0, 2, 5'd11, 64'h0000_0000_FFFF_FFFF);
    set_load(2'd0, 1'b0, 3'd7, 5'd13, 64'h7F00_0000_0000_0000);
    run_load(1'b0, 2, 5'd13, 64'h0000_0000_0000_007F);

    // Reset in WAIT abandons the load
    do_reset(); set_load(2'd2, 1'b0, 3'd0, 5'd14, 64'h1111_2222_3333_4444);
    @(negedge clk);
    check("rw_t0_stall", {63'd0, b_stall}, 64'd1);
    next_cycle();
    rst = 1'b1;
    @(negedge clk);
    check("rw_rst_stall", {63'd0, b_stall}, 64'd0);
    check("rw_rst_waddr", {59'd0, b_waddr}, 64'd0);
    check("rw_rst_wdata", b_wdata, 64'd0);
    next_cycle();
    rst = 1'b0;
    ex_mem_ena = 1'b0; waddr = 5'd3; wdata = 64'h55;
    @(negedge clk);
    check("rw_alu_waddr", {59'd0, b_waddr}, 64'd3);
    check("rw_alu_wdata", b_wdata, 64'h55);
    check("rw_alu_stall", {63'd0, b_stall}, 64'd0);
    next_cycle();

`ifdef MEM_WB_VARLAT_EN
    // Variable latency: rvalid low for four WAIT cycles, then high
    do_reset(); set_load(2'd2, 1'b0, 3'd0, 5'd15, 64'hDEAD_BEEF);
    run_load(1'b1, 5, 5'd15, 64'hDEAD_BEEF);
`endif

    drive_idle();
    next_cycle();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_wb_ctrl.md
Name: mem_wb_ctrl

Overview:
- Parametrised EX→MEM→WB writeback controller for the in-order core.
- Sits between EX, the data-memory read port and the GPRS write port.
- Non-load results write back in the same cycle. Loads stall the pipeline for a configurable read latency, then write back lane-extracted, sign/zero-extended data.
- Generalises the single-cycle load path to any XLEN (32/64) and any fixed read latency, with an optional variable-latency mode.

Parameters:
- XLEN, 32: data width; legal values 32 or 64.
- REG_W, 5: GPRS address width.
- LOAD_LAT, 1: fixed memory read latency in cycles, ≥1.
- OFF_W, $clog2(XLEN/8): width of the byte-offset input.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- ex_valid  in  1  EX holds a valid instruction
- ex_mem_ena  in  1  instruction accesses memory
- mem_rw_i  in  1  `MEM_READ = load, else store
- ex_ld_size  in  2  0=byte, 1=half, 2=word, 3=double (double legal only when XLEN=64)
- ex_ld_unsigned  in  1  zero-extend when 1
- ex_addr_off  in  OFF_W  low address bits (byte lane)
- gprs_waddr_i  in  REG_W  destination register
- gprs_wdata_i  in  XLEN  EX result
- mem_rdata_i  in  XLEN  memory read data, full aligned word
- mem_rvalid_i  in  1  read data valid; used only with the optional feature
- gprs_waddr_o  out  REG_W  GPRS write address; x0 = no write
- gprs_wdata_o  out  XLEN  GPRS write data
- stall  out  1  asynchronously to cpu_ctrl; freezes IF/ID/EX

Reset:
- One clock; reset is synchronous and active-high (clk, rst).

Behaviour:
- States: IDLE, WAIT. Counter cnt is $clog2(LOAD_LAT+1) bits wide.
- While rst=1 (combinational override): gprs_waddr_o=0, gprs_wdata_o=0, stall=0.
- On rst: state←IDLE, cnt←0, captured load fields←0.
- IDLE, non-load path: applies when ex_valid && !ex_mem_ena. Output gprs_waddr_i/gprs_wdata_i combinationally, stall=0.
- IDLE, store or !ex_valid: outputs x0/0, stall=0.
- IDLE, load (ex_valid && ex_mem_ena && mem_rw_i==`MEM_READ):
  - Cycle t0: stall=1 combinationally; outputs x0/0.
  - Capture rd, size, unsigned, offset.
  - cnt←LOAD_LAT-1; state←WAIT.
- WAIT, cnt≠0: stall=1, outputs x0/0, cnt←cnt-1.
- WAIT, cnt==0 (cycle t0+LOAD_LAT, the WB cycle):
  - stall=0.
  - gprs_waddr_o=captured rd; gprs_wdata_o=extract(mem_rdata_i).
  - state←IDLE.
  - EX inputs still hold the same load this cycle; they are ignored and no new load is accepted.
- Net effect: stall is high for exactly LOAD_LAT cycles per load. LOAD_LAT=1 gives the 1-cycle-stall, next-cycle-writeback behaviour.
- Extraction, with lane = captured offset:
  - byte: rdata[8*lane +: 8].
  - half: rdata[16*lane[OFF_W-1:1] +: 16]; offset bit 0 is ignored.
  - word: rdata[32*lane[OFF_W-1:2] +: 32] (XLEN=64); full word when XLEN=32.
  - double: full rdata.
  - Sign-extend from the field MSB unless unsigned=1, then zero-extend.
  - Illegal combinations (size=3 with XLEN=32) return the full rdata.
  - Misalignment is not detected here.
- Load to x0: full stall length still applies; waddr_o=0.
- Back-to-back loads: the second load is accepted in the IDLE cycle after WB. There is no bubble beyond its own stall.
- rst asserted in WAIT: abandons the load, no writeback; stall=0 from that cycle.

Optional Feature:
- Macro: MEM_WB_VARLAT_EN.
- With the macro defined:
  - LOAD_LAT and cnt are unused.
  - WAIT holds stall=1 until mem_rvalid_i=1.
  - The cycle with mem_rvalid_i=1 is the WB cycle: stall=0, writeback, IDLE.
  - mem_rvalid_i is ignored in IDLE, including the accept cycle.
- Without the macro: mem_rvalid_i is ignored, and fixed-latency counting is used.

Test Plan:
- ALU op, ex_valid=1, ex_mem_ena=0, waddr=5, wdata=0x1234 → same cycle waddr_o=5, wdata_o=0x1234, stall=0.
- Store (mem_rw_i≠`MEM_READ), waddr=7 → waddr_o=0, stall=0 every cycle.
- LOAD_LAT=3, XLEN=32, lb, off=2, unsigned=0, rdata=0x0080_0000 at WB → stall high for 3 cycles; 4th cycle waddr_o=rd, wdata_o=0xFFFF_FF80, stall=0.
- XLEN=64, lhu off=6, rdata=0x8001_0000_0000_0000 → wdata_o=0x0000_0000_0000_8001; lwu off=4, rdata=0xFFFF_FFFF_0000_0000 → 0x0000_0000_FFFF_FFFF.
- LOAD_LAT=2: load, rst pulsed in WAIT, then ALU op waddr=3 → no load writeback; ALU writes x3 the cycle after rst drops.
- MEM_WB_VARLAT_EN: load, mem_rvalid_i low 4 cycles then high with lw rdata=0xDEADBEEF → stall high 5 cycles, WB cycle writes 0xDEADBEEF.
